// File: rtl/dtmf_pkg.sv
// dtmf_pkg
// Shared definitions for the DTMF frame sequencer slice:
//   - frame sequencer state encoding
//   - detector bin ranges for the four keypad rows (low group)
//     and the four keypad columns (high group)
//   - keypad code encoding helper (row*4 + col)
//   - default frame/debounce/timeout parameters
package dtmf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_LATCH  = 3'd3,
    ST_DECODE = 3'd4
  } dtmf_state_e;

  localparam int DEF_BIN_COUNT      = 64;
  localparam int DEF_CONFIRM_FRAMES = 3;
  localparam int DEF_READY_TIMEOUT  = 4;

  // Low-group bins -> rows 697/770/852/941 Hz
  localparam logic [5:0] ROW0_LO = 6'd19;
  localparam logic [5:0] ROW0_HI = 6'd20;
  localparam logic [5:0] ROW1_LO = 6'd21;
  localparam logic [5:0] ROW1_HI = 6'd21;
  localparam logic [5:0] ROW2_LO = 6'd22;
  localparam logic [5:0] ROW2_HI = 6'd23;
  localparam logic [5:0] ROW3_LO = 6'd24;
  localparam logic [5:0] ROW3_HI = 6'd25;

  // High-group bins -> columns 1209/1336/1477/1633 Hz
  localparam logic [5:0] COL0_LO = 6'd32;
  localparam logic [5:0] COL0_HI = 6'd34;
  localparam logic [5:0] COL1_LO = 6'd35;
  localparam logic [5:0] COL1_HI = 6'd37;
  localparam logic [5:0] COL2_LO = 6'd38;
  localparam logic [5:0] COL2_HI = 6'd40;
  localparam logic [5:0] COL3_LO = 6'd41;
  localparam logic [5:0] COL3_HI = 6'd43;

  // Keypad code: row in the upper two bits, column in the lower two.
  function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/dtmf_frame_sequencer_if.sv
// dtmf_frame_sequencer_if
// Confirmed-key handshake towards the UART/display logic.
//   key_valid : confirmed key available (held until accepted)
//   key_ready : consumer accepts key
//   key_code  : row*4+col, stable while key_valid is high
// master = sequencer side, slave = consumer side.
interface dtmf_frame_sequencer_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/dtmf_bin_decoder.sv
// dtmf_bin_decoder
// Combinational mapping of the detector's winning bins to a keypad position.
//   low_bin    in  6  low-group winning bin (0 = none)
//   high_bin   in  6  high-group winning bin (0 = none)
//   row        out 2  keypad row (0 when invalid)
//   col        out 2  keypad column (0 when invalid)
//   pair_valid out 1  both row and column fall inside a known range
module dtmf_bin_decoder
  import dtmf_pkg::*;
(
  input  logic [5:0] low_bin,
  input  logic [5:0] high_bin,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       pair_valid
);

  logic row_ok_s;
  logic col_ok_s;

  // Low bin to row lookup
  always_comb begin
    row      = 2'd0;
    row_ok_s = 1'b1;
    if (low_bin >= ROW0_LO && low_bin <= ROW0_HI) begin
      row = 2'd0;
    end else if (low_bin >= ROW1_LO && low_bin <= ROW1_HI) begin
      row = 2'd1;
    end else if (low_bin >= ROW2_LO && low_bin <= ROW2_HI) begin
      row = 2'd2;
    end else if (low_bin >= ROW3_LO && low_bin <= ROW3_HI) begin
      row = 2'd3;
    end else begin
      row      = 2'd0;
      row_ok_s = 1'b0;
    end
  end

  // High bin to column lookup
  always_comb begin
    col      = 2'd0;
    col_ok_s = 1'b1;
    if (high_bin >= COL0_LO && high_bin <= COL0_HI) begin
      col = 2'd0;
    end else if (high_bin >= COL1_LO && high_bin <= COL1_HI) begin
      col = 2'd1;
    end else if (high_bin >= COL2_LO && high_bin <= COL2_HI) begin
      col = 2'd2;
    end else if (high_bin >= COL3_LO && high_bin <= COL3_HI) begin
      col = 2'd3;
    end else begin
      col      = 2'd0;
      col_ok_s = 1'b0;
    end
  end

  assign pair_valid = row_ok_s & col_ok_s;

endmodule

// File: rtl/dtmf_frame_sequencer.sv
// dtmf_frame_sequencer
// Frame-level controller for the DTMF tone detector: waits for a full FFT
// frame, clears the detector, streams BIN_COUNT bins through it, latches the
// low/high winning bins, decodes them to a keypad code and debounces across
// frames. Confirmed presses leave on a valid/ready handshake.
//   clk, reset_n     system clock, synchronous active-low reset
//   fft_frame_valid  FFT buffer holds a full frame (level)
//   fft_rd_en        bin read strobe (show-ahead buffer), STREAM only
//   fft_frame_done   one-cycle buffer release pulse in DECODE
//   det_clear_n      detector reset, low for one cycle per frame and in reset
//   det_enable       detector enable, STREAM only
//   det_ready        detector result ready
//   det_low_bin/det_high_bin  detector winning bins
//   key_if           confirmed key handshake (master side)
//   tone_present     last decoded frame held a valid row+col pair
//   overrun          one-cycle pulse when a confirmed key is dropped
module dtmf_frame_sequencer
  import dtmf_pkg::*;
#(
  parameter int BIN_COUNT      = DEF_BIN_COUNT,
  parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES,
  parameter int READY_TIMEOUT  = DEF_READY_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fft_frame_valid,
  output logic                          fft_rd_en,
  output logic                          fft_frame_done,
  output logic                          det_clear_n,
  output logic                          det_enable,
  input  logic                          det_ready,
  input  logic [5:0]                    det_low_bin,
  input  logic [5:0]                    det_high_bin,
  dtmf_frame_sequencer_if.master        key_if,
  output logic                          tone_present,
  output logic                          overrun
);

  localparam int CW = $clog2(BIN_COUNT);
  localparam int TW = $clog2(READY_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_BIN = CW'(BIN_COUNT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(READY_TIMEOUT - 1);
  localparam logic [3:0]    CONFIRM  = 4'(CONFIRM_FRAMES);

  dtmf_state_e   state_r;
  logic [CW-1:0] bin_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic [5:0]    low_bin_r;
  logic [5:0]    high_bin_r;
  logic          fft_rd_en_r;
  logic          det_enable_r;
  logic          det_clear_n_r;
  logic          fft_frame_done_r;

  logic [3:0]    cand_code_r;
  logic [3:0]    match_cnt_r;
  logic          armed_r;
  logic          tone_present_r;
  logic          key_valid_r;
  logic [3:0]    key_code_r;
  logic          overrun_r;

  logic [1:0]    row_s;
  logic [1:0]    col_s;
  logic          pair_valid_s;
  logic [3:0]    code_s;
  logic [3:0]    match_next_s;
  logic          emit_s;

  dtmf_bin_decoder u_bin_decoder (
    .low_bin    (low_bin_r),
    .high_bin   (high_bin_r),
    .row        (row_s),
    .col        (col_s),
    .pair_valid (pair_valid_s)
  );

  assign code_s = key_code_f(row_s, col_s);

  // Frame sequencing FSM; outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      bin_cnt_r        <= '0;
      to_cnt_r         <= '0;
      low_bin_r        <= 6'd0;
      high_bin_r       <= 6'd0;
      fft_rd_en_r      <= 1'b0;
      det_enable_r     <= 1'b0;
      det_clear_n_r    <= 1'b0;
      fft_frame_done_r <= 1'b0;
    end else begin
      fft_frame_done_r <= 1'b0;
      det_clear_n_r    <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (fft_frame_valid) begin
            state_r       <= ST_CLEAR;
            det_clear_n_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_r      <= ST_STREAM;
          bin_cnt_r    <= '0;
          fft_rd_en_r  <= 1'b1;
          det_enable_r <= 1'b1;
        end
        ST_STREAM: begin
          if (bin_cnt_r == LAST_BIN) begin
            state_r      <= ST_LATCH;
            fft_rd_en_r  <= 1'b0;
            det_enable_r <= 1'b0;
            to_cnt_r     <= '0;
          end else begin
            bin_cnt_r <= bin_cnt_r + 1'b1;
          end
        end
        ST_LATCH: begin
          if (det_ready) begin
            low_bin_r        <= det_low_bin;
            high_bin_r       <= det_high_bin;
            state_r          <= ST_DECODE;
            fft_frame_done_r <= 1'b1;
          end else if (to_cnt_r == TO_LAST) begin
            // Detector never answered: treat the frame as silence.
            low_bin_r        <= 6'd0;
            high_bin_r       <= 6'd0;
            state_r          <= ST_DECODE;
            fft_frame_done_r <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        ST_DECODE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          fft_rd_en_r  <= 1'b0;
          det_enable_r <= 1'b0;
        end
      endcase
    end
  end

  // Debounce next-count and emit decision for the frame being decoded
  always_comb begin
    match_next_s = 4'd1;
    emit_s       = 1'b0;
    if (code_s == cand_code_r) begin
      match_next_s = (match_cnt_r >= CONFIRM) ? CONFIRM : (match_cnt_r + 4'd1);
    end else begin
      match_next_s = 4'd1;
    end
    if (state_r == ST_DECODE && pair_valid_s && armed_r && match_next_s == CONFIRM) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
  end

  // Debouncer state; armed re-opens only after a silent/invalid frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_code_r    <= 4'd0;
      match_cnt_r    <= 4'd0;
      armed_r        <= 1'b1;
      tone_present_r <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      tone_present_r <= pair_valid_s;
      if (pair_valid_s) begin
        cand_code_r <= code_s;
        match_cnt_r <= match_next_s;
        if (emit_s) begin
          armed_r <= 1'b0;
        end
      end else begin
        match_cnt_r <= 4'd0;
        armed_r     <= 1'b1;
      end
    end
  end

  // Key output handshake; a pending unaccepted key is kept and the new one dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (emit_s) begin
        if (!key_valid_r || key_if.key_ready) begin
          key_valid_r <= 1'b1;
          key_code_r  <= code_s;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (key_valid_r && key_if.key_ready) begin
        key_valid_r <= 1'b0;
      end
    end
  end

  assign fft_rd_en        = fft_rd_en_r;
  assign fft_frame_done   = fft_frame_done_r;
  assign det_clear_n      = det_clear_n_r;
  assign det_enable       = det_enable_r;
  assign tone_present     = tone_present_r;
  assign overrun          = overrun_r;
  assign key_if.key_valid = key_valid_r;
  assign key_if.key_code  = key_code_r;

endmodule

// File: tb/tb_dtmf_frame_sequencer.sv
// tb_dtmf_frame_sequencer
// Table-driven frame vectors (one record per FFT frame with the detector
// answer and the expected key/tone/overrun state in the cycle after DECODE),
// plus hand-written reset and mid-frame-reset sequences.
module tb_dtmf_frame_sequencer;

  logic       clk;
  logic       reset_n;
  logic       fft_frame_valid;
  logic       fft_rd_en;
  logic       fft_frame_done;
  logic       det_clear_n;
  logic       det_enable;
  logic       det_ready;
  logic [5:0] det_low_bin;
  logic [5:0] det_high_bin;
  logic       tone_present;
  logic       overrun;

  dtmf_frame_sequencer_if key_if ();

  dtmf_frame_sequencer #(
    .BIN_COUNT      (64),
    .CONFIRM_FRAMES (3),
    .READY_TIMEOUT  (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fft_frame_valid (fft_frame_valid),
    .fft_rd_en       (fft_rd_en),
    .fft_frame_done  (fft_frame_done),
    .det_clear_n     (det_clear_n),
    .det_enable      (det_enable),
    .det_ready       (det_ready),
    .det_low_bin     (det_low_bin),
    .det_high_bin    (det_high_bin),
    .key_if          (key_if),
    .tone_present    (tone_present),
    .overrun         (overrun)
  );

  typedef struct {
    logic [5:0] low;
    logic [5:0] high;
    logic       rdy;
    logic       krdy;
    logic       tone;
    logic       kv;
    logic [3:0] code;
    logic       ov;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  int   ov_cnt   = 0;
  int   rise_cnt = 0;
  logic kv_prev  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled between edges
  always @(posedge clk) begin
    #2;
    if (fft_frame_done === 1'b1) done_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (key_if.key_valid === 1'b1 && kv_prev === 1'b0) rise_cnt++;
    kv_prev = key_if.key_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int lo, input int hi, input int rdy, input int krdy,
                     input int tone, input int kv, input int code, input int ov);
    vec_t v;
    v.low  = 6'(lo);
    v.high = 6'(hi);
    v.rdy  = 1'(rdy);
    v.krdy = 1'(krdy);
    v.tone = 1'(tone);
    v.kv   = 1'(kv);
    v.code = 4'(code);
    v.ov   = 1'(ov);
    vecs.push_back(v);
  endtask

  // Wait for CLEAR already observed, then count cycles up to and including DECODE
  task automatic finish_frame(input string tag, input int exp_len);
    int len;
    int rd;
    int en;
    len = 1;
    rd  = 0;
    en  = 0;
    while (fft_frame_done !== 1'b1 && len < 200) begin
      @(negedge clk);
      len++;
      if (fft_rd_en === 1'b1) rd++;
      if (det_enable === 1'b1) en++;
    end
    fft_frame_valid = 1'b0;
    check({tag, " frame_len"}, len, exp_len);
    check({tag, " rd_en_cycles"}, rd, 64);
    check({tag, " det_enable_cycles"}, en, 64);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int    guard;
    string tag;
    tag = $sformatf("frame%0d", idx);
    @(negedge clk);
    det_low_bin     = v.low;
    det_high_bin    = v.high;
    det_ready       = v.rdy;
    key_if.key_ready = v.krdy;
    fft_frame_valid = 1'b1;
    guard = 0;
    while (det_clear_n !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " clear_seen"}, int'(det_clear_n), 0);
    finish_frame(tag, v.rdy ? 67 : 70);
    @(negedge clk);
    check({tag, " tone_present"}, int'(tone_present), int'(v.tone));
    check({tag, " key_valid"}, int'(key_if.key_valid), int'(v.kv));
    check({tag, " overrun"}, int'(overrun), int'(v.ov));
    if (v.kv) check({tag, " key_code"}, int'(key_if.key_code), int'(v.code));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fft_rd_en"}, int'(fft_rd_en), 0);
    check({tag, " fft_frame_done"}, int'(fft_frame_done), 0);
    check({tag, " det_clear_n"}, int'(det_clear_n), 0);
    check({tag, " det_enable"}, int'(det_enable), 0);
    check({tag, " key_valid"}, int'(key_if.key_valid), 0);
    check({tag, " key_code"}, int'(key_if.key_code), 0);
    check({tag, " tone_present"}, int'(tone_present), 0);
    check({tag, " overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int done_snap;
    int frames;
    reset_n          = 1'b0;
    fft_frame_valid  = 1'b0;
    det_ready        = 1'b0;
    det_low_bin      = 6'd0;
    det_high_bin     = 6'd0;
    key_if.key_ready = 1'b0;

    //      lo  hi rdy krdy tone kv code ov
    // three 19/32 frames -> key 0
    add(19, 32, 1, 1, 1, 0, 0, 0);
    add(19, 32, 1, 1, 1, 0, 0, 0);
    add(19, 32, 1, 1, 1, 1, 0, 0);
    add( 0,  0, 1, 1, 0, 0, 0, 0);
    // 24/41 x2, then 22/35 x3 -> key 9 on the third 22/35
    add(24, 41, 1, 1, 1, 0, 0, 0);
    add(24, 41, 1, 1, 1, 0, 0, 0);
    add(22, 35, 1, 1, 1, 0, 0, 0);
    add(22, 35, 1, 1, 1, 0, 0, 0);
    add(22, 35, 1, 1, 1, 1, 9, 0);
    add( 0,  0, 1, 1, 0, 0, 0, 0);
    // 21/38 x5 -> one emit of 6; release; x3 -> second emit
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add(21, 38, 1, 1, 1, 1, 6, 0);
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add( 0,  0, 1, 1, 0, 0, 0, 0);
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add(21, 38, 1, 1, 1, 0, 0, 0);
    add(21, 38, 1, 1, 1, 1, 6, 0);
    add( 0,  0, 1, 1, 0, 0, 0, 0);
    // consumer stalled: key 0 retained, key 15 dropped with overrun
    add(19, 32, 1, 0, 1, 0, 0, 0);
    add(19, 32, 1, 0, 1, 0, 0, 0);
    add(19, 32, 1, 0, 1, 1, 0, 0);
    add( 0,  0, 1, 0, 0, 1, 0, 0);
    add(24, 41, 1, 0, 1, 1, 0, 0);
    add(24, 41, 1, 0, 1, 1, 0, 0);
    add(24, 41, 1, 0, 1, 1, 0, 1);
    add(24, 41, 1, 0, 1, 1, 0, 0);
    // detector never ready -> timeout, treated as silence
    add(19, 32, 0, 1, 0, 0, 0, 0);
    // range edges
    add(20, 34, 1, 1, 1, 0, 0, 0);
    add(25, 43, 1, 1, 1, 0, 0, 0);
    add(18, 32, 1, 1, 0, 0, 0, 0);
    add(20, 44, 1, 1, 0, 0, 0, 0);
    add(26, 31, 1, 1, 0, 0, 0, 0);
    add(21, 37, 1, 1, 1, 0, 0, 0);
    add(23, 40, 1, 1, 1, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset det_clear_n", int'(det_clear_n), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i], i);
    end
    frames = vecs.size();

    // reset at STREAM bin 30 aborts the frame; buffer still full restarts it
    @(negedge clk);
    det_low_bin      = 6'd19;
    det_high_bin     = 6'd32;
    det_ready        = 1'b1;
    key_if.key_ready = 1'b1;
    fft_frame_valid  = 1'b1;
    begin
      int guard;
      guard = 0;
      while (det_clear_n !== 1'b0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    check("midreset clear_seen", int'(det_clear_n), 0);
    repeat (31) @(negedge clk);
    check("midreset rd_en_at_bin30", int'(fft_rd_en), 1);
    done_snap = done_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset no_done", done_cnt, done_snap);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart clear", int'(det_clear_n), 0);
    check("restart rd_en_in_clear", int'(fft_rd_en), 0);
    finish_frame("restart", 67);
    frames++;
    @(negedge clk);
    check("restart tone_present", int'(tone_present), 1);
    check("restart key_valid", int'(key_if.key_valid), 0);

    repeat (2) @(negedge clk);
    check("total frame_done pulses", done_cnt, frames);
    check("total overrun pulses", ov_cnt, 1);
    check("total key_valid rises", rise_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
